// File: rtl/dram_arbiter.sv
// Two-requester (core / debug loader) arbiter in front of a single-port synchronous DRAM.
// Define DRAM_ARB_CPU_PRIO_EN for fixed CPU priority on ties; otherwise ties go round-robin.
module dram_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [31:0]       dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   logic [1:0] state;
   logic       owner;
   logic       last;
   logic       grant;
   logic       grant_dbg;
   logic       resp;
   logic       unused_addr_bits;

   // Byte offset and bits above the DRAM size are dropped: word access, address wraps.
   assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                               dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

   always_comb begin
      grant     = 1'b0;
      grant_dbg = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cpu_req | dbg_req) begin
               grant = 1'b1;
`ifdef DRAM_ARB_CPU_PRIO_EN
               grant_dbg = ~cpu_req;
`else
               grant_dbg = dbg_req & (~cpu_req | ~last);
`endif
            end
         end
         // Only the non-owner may chain straight into a new access.
         ST_RESP: begin
            if (owner ? cpu_req : dbg_req) begin
               grant     = 1'b1;
               grant_dbg = ~owner;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         owner     <= 1'b0;
         last      <= 1'b1;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= grant;
         mem_we <= grant & (grant_dbg ? dbg_we : cpu_we);
         if (state == ST_RESP) begin
            last <= owner;
         end
         if (grant) begin
            owner     <= grant_dbg;
            mem_addr  <= grant_dbg ? dbg_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
            mem_wdata <= grant_dbg ? dbg_wdata : cpu_wdata;
            state     <= ST_ISSUE;
         end else if (state == ST_ISSUE) begin
            state <= ST_RESP;
         end else begin
            state <= ST_IDLE;
         end
      end
   end

   assign resp      = (state == ST_RESP);
   assign cpu_ready = resp & ~owner;
   assign dbg_ready = resp & owner;
   assign cpu_rdata = cpu_ready ? mem_rdata : '0;
   assign dbg_rdata = dbg_ready ? mem_rdata : '0;
   assign cpu_stall = cpu_req & ~cpu_ready;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant timestamps and a reference memory).
module tb_dram_arbiter;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef DRAM_ARB_CPU_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0]       cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ready, cpu_stall;
   logic              dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0]       dbg_addr = '0;
   logic [DATA_W-1:0] dbg_wdata = '0;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_ready;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port DRAM stub.
   logic [DATA_W-1:0] dram [0:DEPTH-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) dram[mem_addr] <= mem_wdata;
         else        mem_rdata <= dram[mem_addr];
      end
   end

   // Reference model state.
   logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
   int                checks = 0;
   int                failures = 0;
   int                cyc = 0;
   int                g_cyc = -100;
   bit                g_who = 1'b0;
   bit                g_we = 1'b0;
   logic [ADDR_W-1:0] g_addr = '0;
   logic [DATA_W-1:0] g_wdata = '0;
   logic [DATA_W-1:0] g_rd = '0;
   bit                m_last = 1'b1;
   bit                e_cpu_rdy = 1'b0;
   bit                e_dbg_rdy = 1'b0;

   function automatic logic [DATA_W-1:0] init_val(input int i);
      return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cyc = 0; g_cyc = -100; g_who = 1'b0; g_we = 1'b0;
      g_addr = '0; g_wdata = '0; m_last = 1'b1;
      e_cpu_rdy = 1'b0; e_dbg_rdy = 1'b0;
   endtask

   task automatic grant(input bit who);
      logic [31:0] a;
      g_cyc   = cyc;
      g_who   = who;
      g_we    = who ? dbg_we : cpu_we;
      a       = who ? dbg_addr : cpu_addr;
      g_addr  = a[ADDR_W+1:2];
      g_wdata = who ? dbg_wdata : cpu_wdata;
      if (g_we) ref_mem[g_addr] = g_wdata;
      else      g_rd = ref_mem[g_addr];
   endtask

   // One clock: check outputs at the falling edge, advance the model, return #1 after the next rising edge.
   task automatic step();
      int d;
      bit e_en;
      @(negedge clk);
      d = cyc - g_cyc;
      e_en = (d == 1);
      e_cpu_rdy = (d == 2) && !g_who;
      e_dbg_rdy = (d == 2) && g_who;
      check("mem_en", mem_en, e_en);
      check("mem_we", mem_we, e_en & g_we);
      check("mem_addr", mem_addr, g_addr);
      check("mem_wdata", mem_wdata, g_wdata);
      check("cpu_ready", cpu_ready, e_cpu_rdy);
      check("dbg_ready", dbg_ready, e_dbg_rdy);
      check("cpu_stall", cpu_stall, cpu_req & !e_cpu_rdy);
      if (!e_cpu_rdy)  check("cpu_rdata_idle", cpu_rdata, 0);
      else if (!g_we)  check("cpu_rdata", cpu_rdata, g_rd);
      if (!e_dbg_rdy)  check("dbg_rdata_idle", dbg_rdata, 0);
      else if (!g_we)  check("dbg_rdata", dbg_rdata, g_rd);
      if (d == 2) begin
         m_last = g_who;
         if (g_who ? cpu_req : dbg_req) grant(!g_who);
      end else if (d != 1 && (cpu_req || dbg_req)) begin
         if (cpu_req && dbg_req) grant(PRIO ? 1'b0 : !m_last);
         else                    grant(dbg_req);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic rand_fields(output logic we, output logic [31:0] addr, output logic [DATA_W-1:0] wd);
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      wd   = $urandom;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         dram[i]    = init_val(i);
         ref_mem[i] = init_val(i);
      end

      // Reset values, with a CPU request visible on the stall output.
      cpu_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_ready", cpu_ready, 0);
      check("rst_dbg_ready", dbg_ready, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_dbg_rdata", dbg_rdata, 0);
      check("rst_cpu_stall", cpu_stall, 1);
      do_reset();

      // CPU load of byte address 0x10.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      step();
      check("ld_mem_en", mem_en, 1);
      check("ld_mem_addr", mem_addr, 4);
      check("ld_stall_c1", cpu_stall, 1);
      step();
      check("ld_ready", cpu_ready, 1);
      check("ld_rdata", cpu_rdata, init_val(4));
      check("ld_stall_c2", cpu_stall, 0);
      step();
      cpu_req = 1'b0;
      step();

      // DBG store, then CPU read-back.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_wdata = 32'hDEAD_BEEF;
      step();
      check("st_mem_we", mem_we, 1);
      check("st_mem_addr", mem_addr, 8);
      step();
      check("st_ready", dbg_ready, 1);
      step();
      dbg_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      step();
      step();
      check("rb_rdata", cpu_rdata, 32'hDEAD_BEEF);
      step();
      cpu_req = 1'b0;
      step();

      // Both requesters held from reset: CPU, DBG, CPU, DBG.
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h80;
      for (int k = 1; k <= 8; k++) begin
         step();
         check("tie_cpu_ready", cpu_ready, (k == 2 || k == 6));
         check("tie_dbg_ready", dbg_ready, (k == 4 || k == 8));
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (4) step();

      // Address change after grant must not alter the access.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
      step();
      cpu_addr = 32'h200;
      check("chg_addr_c1", mem_addr, 64);
      step();
      check("chg_addr_c2", mem_addr, 64);
      check("chg_en_c2", mem_en, 0);
      step();
      cpu_req = 1'b0;
      repeat (2) step();

      // Reset pulse during ISSUE.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h14;
      step();
      check("rsti_en_before", mem_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rsti_en_async", mem_en, 0);
      check("rsti_ready", cpu_ready, 0);
      cpu_req = 1'b0;
      @(posedge clk);
      #1;
      check("rsti_no_ready", cpu_ready, 0);
      rst_n = 1'b1;
      model_reset();
      cpu_req = 1'b1; cpu_addr = 32'h30;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h34;
      step();
      check("rsti_tie_cpu", mem_addr, 12);
      step();
      step();
      cpu_req = 1'b0; dbg_req = 1'b0;
      repeat (3) step();

      // Address wrap.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FFFC;
      step();
      check("wrap_addr", mem_addr, 14'h3FFF);
      step();
      step();
      cpu_req = 1'b0;
      step();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         if (cpu_req) begin
            if (e_cpu_rdy) begin
               if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
               else rand_fields(cpu_we, cpu_addr, cpu_wdata);
            end else if ($urandom_range(0, 49) == 0) begin
               cpu_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               rand_fields(cpu_we, cpu_addr, cpu_wdata);
            end
         end else if ($urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1;
            rand_fields(cpu_we, cpu_addr, cpu_wdata);
         end
         if (dbg_req) begin
            if (e_dbg_rdy) begin
               if ($urandom_range(0, 1) == 0) dbg_req = 1'b0;
               else rand_fields(dbg_we, dbg_addr, dbg_wdata);
            end else if ($urandom_range(0, 49) == 0) begin
               dbg_req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               rand_fields(dbg_we, dbg_addr, dbg_wdata);
            end
         end else if ($urandom_range(0, 2) == 0) begin
            dbg_req = 1'b1;
            rand_fields(dbg_we, dbg_addr, dbg_wdata);
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter placed between the single-cycle core's data-memory port, a debug/DMA loader port and one single-port synchronous DRAM. Each access is serialised to the DRAM with a fixed 2-cycle issue/response sequence, and each requester gets a one-cycle `ready` pulse when its access completes. `cpu_stall` freezes the core's PC/register-file write while its load/store is pending. Without the priority macro, simultaneous requests are resolved round-robin.

## Interface
- `ADDR_W`, 14: DRAM word-address width; `mem_addr` = requester `addr[ADDR_W+1:2]`.
- `DATA_W`, 32: data width.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  core access request; held until `cpu_ready`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  32  byte address (ALU result).
- `cpu_wdata`  in  DATA_W  store data (rs2).
- `cpu_rdata`  out  DATA_W  load data, valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_stall`  out  1  `cpu_req & ~cpu_ready` (combinational).
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ready`: same as the `cpu_*` ports, for the loader.
- `mem_en`  out  1  DRAM access strobe (registered).
- `mem_we`  out  1  DRAM write enable (registered; 0 whenever `mem_en`=0).
- `mem_addr`  out  ADDR_W  DRAM word address (registered).
- `mem_wdata`  out  DATA_W  DRAM write data (registered).
- `mem_rdata`  in  DATA_W  DRAM read data, valid the cycle after `mem_en`.

## Operation
- FSM states: IDLE, ISSUE, RESP. Register `owner` (0 = CPU, 1 = DBG). Register `last`: owner of the most recent completed grant.
- IDLE:
  - no request → stay in IDLE.
  - any `req` → choose winner, latch winner's `we`/`addr`/`wdata` into the `mem_*` registers, set `owner`, go to ISSUE.
- ISSUE: `mem_en`=1 for exactly this cycle; go to RESP.
- RESP:
  - `ready` of `owner` = 1; that requester's `rdata` = `mem_rdata`; `last` ← `owner`.
  - If the non-owner's `req`=1 → latch it and go to ISSUE (the owner's `req` is ignored this cycle).
  - Otherwise → IDLE.
- Round-robin: if both request in IDLE, the winner is `~last`. A single requester always wins.
- Writes also complete in RESP with the same latency. `rdata` is don't-care for a write, but is driven as `mem_rdata`.
- Non-owner `rdata` = 0; `ready` = 0 outside RESP.
- Requester fields are sampled only at grant. Changes after grant are ignored.
- Protocol violation (`req` dropped before `ready`): the access still completes and `ready` still pulses.

## Timing
- Reset values: state = IDLE, `owner` = 0, `last` = 1 (CPU wins the first tie). All outputs are 0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both `ready`, both `rdata`. `cpu_stall` = `cpu_req`.
- Latency from `req` first high in IDLE (cycle 0): `mem_en` at cycle 1, `ready` at cycle 2.
- Back-to-back access by the other requester: `mem_en` at cycle 3, `ready` at cycle 4.
- Same requester re-requesting immediately: passes through IDLE; minimum 3 cycles per access.
- Reset asserted mid-access: immediate return to IDLE; the pending access is dropped with no `ready`; `mem_en` is forced to 0 asynchronously.
- `ADDR_W` truncation: upper address bits are ignored (the address wraps modulo DRAM size). `addr[1:0]` are ignored (word access only).

## Configuration
- `DRAM_ARB_CPU_PRIO_EN`:
  - Defined: fixed priority; CPU always wins a tie in IDLE. In RESP after a CPU access, a pending DBG request is still granted next, which keeps DBG starvation-free.
  - Undefined: round-robin as above.

## Test plan
- Reset, then CPU load: `cpu_req`=1, `we`=0, `addr`=0x0000_0010 → `mem_en`=1 with `mem_addr`=4 at cycle 1; `cpu_ready`=1 with `cpu_rdata`=DRAM[4] at cycle 2; `cpu_stall`=1 for cycles 0–1 only.
- DBG store: `dbg_we`=1, `addr`=0x20, `wdata`=0xDEADBEEF → `mem_we`=1, `mem_addr`=8 at cycle 1; `dbg_ready` at cycle 2; a subsequent CPU load of 0x20 returns 0xDEADBEEF.
- Simultaneous requests from reset, both held: grant order CPU, DBG, CPU, DBG. `ready` pulses at cycles 2, 4, 6, 8. With `DRAM_ARB_CPU_PRIO_EN` defined, the first grant is still CPU and the order is still alternating.
- `cpu_addr` changed during ISSUE: `mem_addr` keeps the value latched at grant; no second `mem_en` is issued.
- `rst_n` pulsed low during ISSUE: `mem_en` drops immediately; no `ready` pulse; state = IDLE; the next tie goes to CPU.
- `addr` = 0xFFFF_FFFC with `ADDR_W`=14 → `mem_addr` = 0x3FFF.
